// File: rtl/go_pkg.sv
// Shared types for the Go board engine: cell encoding, controller states and
// the packed history entry recorded for every accepted move.
package go_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COMMIT,
    CLR,
    REPLAY,
    OVER
  } state_t;

  // Coordinates are stored at the widest legal board width (19 -> 5 bits)
  // so one entry type serves every board size.
  localparam int COORD_W_MAX = 5;

  typedef struct packed {
    logic                   pass;
    logic [COORD_W_MAX-1:0] row;
    logic [COORD_W_MAX-1:0] col;
  } hist_entry_t;

  function automatic int cell_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/go_move_history.sv
// Move history: DEPTH-entry register file filled in order, with a running
// count, a sticky overflow flag and one combinational read port.
module go_move_history
  import go_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int HIST_W = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_en,
  input  hist_entry_t       wr_entry,
  input  logic [PTR_W-1:0]  rd_idx,
  output hist_entry_t       rd_entry,
  output logic [HIST_W-1:0] count,
  output logic              overflow
);

  hist_entry_t       mem_q [DEPTH];
  logic [HIST_W-1:0] count_q;
  logic              overflow_q;
  logic              full;

  // The count doubles as the write pointer since entries are only appended.
  assign full = (count_q == HIST_W'(DEPTH));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (wr_en) begin
      if (full) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && !full) begin
      mem_q[count_q[PTR_W-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_idx];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/go_board_engine.sv
// N x N Go board engine: validates and places moves, alternates turns, detects
// the double-pass game end and replays the first k recorded moves on demand.
module go_board_engine
  import go_pkg::*;
#(
  parameter  int N       = 9,
  parameter  int DEPTH   = 64,
  localparam int COORD_W = $clog2(N),
  localparam int HIST_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic               move_pass,
  input  logic [COORD_W-1:0] move_row,
  input  logic [COORD_W-1:0] move_col,
  output logic               move_done,
  output logic               move_err,
  output logic               turn,
  output logic               game_over,
  output logic [2*N*N-1:0]   board,
  input  logic               review_req,
  input  logic [HIST_W-1:0]  review_idx,
  output logic [2*N*N-1:0]   view_board,
  output logic               view_valid,
  output logic [HIST_W-1:0]  hist_count,
  output logic               hist_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state_q, state_d;
  logic [2*N*N-1:0]    board_q, view_q;
  logic                turn_q, streak_q, game_over_q, view_valid_q;
  logic                err_q, ret_over_q, pass_q;
  logic [COORD_W-1:0]  row_q, col_q;
  logic [HIST_W-1:0]   idx_q, rep_cnt_q, rep_cnt_nxt, idx_clamped;

  logic                in_range, accept, mv_go, rev_go, hist_wr;
  int                  lin, rlin;
  logic [1:0]          cell_at;
  hist_entry_t         wr_entry, rd_entry;
  logic [HIST_W-1:0]   hist_count_w;
  logic                hist_overflow_w;

  go_move_history #(.DEPTH(DEPTH)) u_hist (
    .clk_in   (clk_in),
    .reset    (reset),
    .wr_en    (hist_wr),
    .wr_entry (wr_entry),
    .rd_idx   (rep_cnt_q[PTR_W-1:0]),
    .rd_entry (rd_entry),
    .count    (hist_count_w),
    .overflow (hist_overflow_w)
  );

  // Legality of the latched move, evaluated while in CHECK.
  always_comb begin
    in_range = (int'(row_q) < N) && (int'(col_q) < N);
    lin      = in_range ? cell_idx(int'(row_q), int'(col_q), N) : 0;
    cell_at  = board_q[2*lin +: 2];
    accept   = pass_q || (in_range && (cell_at == EMPTY));
    rlin     = cell_idx(int'(rd_entry.row), int'(rd_entry.col), N);
  end

  assign mv_go       = (state_q == IDLE) && move_valid;
  assign rev_go      = review_req && !hist_overflow_w &&
                       (((state_q == IDLE) && !move_valid) || (state_q == OVER));
  assign idx_clamped = (review_idx > hist_count_w) ? hist_count_w : review_idx;
  assign rep_cnt_nxt = rep_cnt_q + 1'b1;
  assign hist_wr     = (state_q == CHECK) && accept;
  assign wr_entry    = '{pass: pass_q,
                         row:  COORD_W_MAX'(row_q),
                         col:  COORD_W_MAX'(col_q)};

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    move_ready = 1'b0;
    move_done  = 1'b0;
    move_err   = 1'b0;
    case (state_q)
      IDLE: begin
        move_ready = 1'b1;
        if (mv_go) begin
          state_d = CHECK;
        end else if (rev_go) begin
          state_d = CLR;
        end
      end
      CHECK:  state_d = COMMIT;
      COMMIT: begin
        move_done = 1'b1;
        move_err  = err_q;
        state_d   = game_over_q ? OVER : IDLE;
      end
      CLR: begin
        if (idx_q == '0) begin
          state_d = ret_over_q ? OVER : IDLE;
        end else begin
          state_d = REPLAY;
        end
      end
      REPLAY: begin
        if (rep_cnt_nxt == idx_q) begin
          state_d = ret_over_q ? OVER : IDLE;
        end
      end
      OVER: begin
        if (rev_go) begin
          state_d = CLR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      board_q      <= '0;
      view_q       <= '0;
      turn_q       <= 1'b0;
      streak_q     <= 1'b0;
      game_over_q  <= 1'b0;
      view_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ret_over_q   <= 1'b0;
      pass_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      rep_cnt_q    <= '0;
    end else begin
      if (mv_go) begin
        row_q  <= move_row;
        col_q  <= move_col;
        pass_q <= move_pass;
      end
      if (rev_go) begin
        idx_q        <= idx_clamped;
        view_valid_q <= 1'b0;
        ret_over_q   <= (state_q == OVER);
      end
      case (state_q)
        CHECK: begin
          err_q <= ~accept;
          if (accept) begin
            turn_q <= ~turn_q;
            if (pass_q) begin
              streak_q <= 1'b1;
              if (streak_q) begin
                game_over_q <= 1'b1;
              end
            end else begin
              streak_q             <= 1'b0;
              board_q[2*lin +: 2]  <= turn_q ? WHITE : BLACK;
            end
          end
        end
        CLR: begin
          view_q    <= '0;
          rep_cnt_q <= '0;
          if (idx_q == '0) begin
            view_valid_q <= 1'b1;
          end
        end
        REPLAY: begin
          // Replay colour follows entry parity; passes occupy an index too.
          if (!rd_entry.pass) begin
            view_q[2*rlin +: 2] <= rep_cnt_q[0] ? WHITE : BLACK;
          end
          rep_cnt_q <= rep_cnt_nxt;
          if (rep_cnt_nxt == idx_q) begin
            view_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign turn          = turn_q;
  assign game_over     = game_over_q;
  assign board         = board_q;
  assign view_board    = view_q;
  assign view_valid    = view_valid_q;
  assign hist_count    = hist_count_w;
  assign hist_overflow = hist_overflow_w;

endmodule

// File: tb/tb_go_board_engine.sv
// Bench for go_board_engine: a 9x9/64-entry engine and a 19x19/4-entry engine
// driven through shared tasks and checked against a board/queue model.
module tb_go_board_engine;

  localparam int BW = 722;

  logic       clk_in = 1'b0;
  logic       reset, mv, mp, rq, sel;
  logic [4:0] mr, mc;
  logic [6:0] ri;

  logic         a_ready, a_done, a_err, a_turn, a_go, a_vv, a_ovf;
  logic [161:0] a_board, a_view;
  logic [6:0]   a_hc;
  logic         b_ready, b_done, b_err, b_turn, b_go, b_vv, b_ovf;
  logic [721:0] b_board, b_view;
  logic [2:0]   b_hc;

  logic          o_ready, o_done, o_err, o_turn, o_go, o_vv, o_ovf;
  logic [BW-1:0] o_board, o_view;
  logic [6:0]    o_hc;

  always #5 clk_in = ~clk_in;

  go_board_engine #(.N(9), .DEPTH(64)) dut_a (
    .clk_in(clk_in), .reset(reset),
    .move_valid(mv && !sel), .move_ready(a_ready), .move_pass(mp),
    .move_row(mr[3:0]), .move_col(mc[3:0]),
    .move_done(a_done), .move_err(a_err), .turn(a_turn), .game_over(a_go),
    .board(a_board), .review_req(rq && !sel), .review_idx(ri),
    .view_board(a_view), .view_valid(a_vv), .hist_count(a_hc),
    .hist_overflow(a_ovf)
  );

  go_board_engine #(.N(19), .DEPTH(4)) dut_b (
    .clk_in(clk_in), .reset(reset),
    .move_valid(mv && sel), .move_ready(b_ready), .move_pass(mp),
    .move_row(mr), .move_col(mc),
    .move_done(b_done), .move_err(b_err), .turn(b_turn), .game_over(b_go),
    .board(b_board), .review_req(rq && sel), .review_idx(ri[2:0]),
    .view_board(b_view), .view_valid(b_vv), .hist_count(b_hc),
    .hist_overflow(b_ovf)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_turn  = sel ? b_turn  : a_turn;
  assign o_go    = sel ? b_go    : a_go;
  assign o_vv    = sel ? b_vv    : a_vv;
  assign o_ovf   = sel ? b_ovf   : a_ovf;
  assign o_board = sel ? b_board : BW'(a_board);
  assign o_view  = sel ? b_view  : BW'(a_view);
  assign o_hc    = sel ? 7'(b_hc) : a_hc;

  // Reference model state
  int            n_cur, depth_cur;
  int            mb [19][19];
  int            mturn;
  int            hist [$];
  bit            mstreak, mover, movf, mvv;
  logic [BW-1:0] mview;
  int            vectors, miscompares;

  task automatic check(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [BW-1:0] exp_board();
    logic [BW-1:0] v;
    v = '0;
    for (int r = 0; r < n_cur; r++)
      for (int c = 0; c < n_cur; c++)
        v[2*(r*n_cur+c) +: 2] = 2'(mb[r][c]);
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_view(input int k);
    logic [BW-1:0] v;
    int e;
    v = '0;
    for (int i = 0; i < k; i++) begin
      e = hist[i];
      if (e >= 0) v[2*((e/32)*n_cur + e%32) +: 2] = (i % 2 == 1) ? 2'b10 : 2'b01;
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 19; r++)
      for (int c = 0; c < 19; c++) mb[r][c] = 0;
    mturn = 0; hist.delete();
    mstreak = 0; mover = 0; movf = 0; mvv = 0; mview = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_in); reset = 1'b1; mv = 1'b0; rq = 1'b0;
    @(posedge clk_in); #1;
    model_clear();
    check("rst_board", o_board, '0);
    check("rst_view", o_view, '0);
    check("rst_turn", BW'(o_turn), '0);
    check("rst_hist", BW'(o_hc), '0);
    check("rst_over", BW'(o_go), '0);
    check("rst_ovf", BW'(o_ovf), '0);
    check("rst_done_err", BW'({o_done, o_err}), '0);
    check("rst_vv", BW'(o_vv), '0);
    @(negedge clk_in); reset = 1'b0;
    @(posedge clk_in); #1;
    check("rst_ready", BW'(o_ready), BW'(1));
  endtask

  task automatic do_move(input bit p, input int r, input int c);
    int  waitc;
    bit  exp_err;
    waitc = 0;
    @(negedge clk_in);
    while (!o_ready && waitc < 20) begin @(negedge clk_in); waitc++; end
    if (!o_ready) begin
      check("ready_timeout", BW'(o_ready), BW'(1));
      return;
    end
    mv = 1'b1; mp = p; mr = 5'(r); mc = 5'(c);
    @(posedge clk_in); #1;
    mv = 1'b0;
    check("t1_ready_done", BW'({o_ready, o_done}), '0);
    exp_err = 1'b0;
    if (!p) begin
      if (r >= n_cur || c >= n_cur) exp_err = 1'b1;
      else if (mb[r][c] != 0) exp_err = 1'b1;
    end
    if (!exp_err) begin
      if (p) begin
        if (mstreak) mover = 1'b1;
        mstreak = 1'b1;
      end else begin
        mstreak = 1'b0;
        mb[r][c] = (mturn == 1) ? 2 : 1;
      end
      mturn ^= 1;
      if (hist.size() < depth_cur) hist.push_back(p ? -1 : r*32 + c);
      else movf = 1'b1;
    end
    @(posedge clk_in); #1;
    $display("move sel=%0d pass=%0d (%0d,%0d) err=%0d exp_err=%0d hc=%0d", sel, p, r, c,
             o_err, exp_err, o_hc);
    check("t2_done", BW'(o_done), BW'(1));
    check("t2_err", BW'(o_err), BW'(exp_err));
    check("t2_board", o_board, exp_board());
    check("t2_turn", BW'(o_turn), BW'(mturn));
    check("t2_hist", BW'(o_hc), BW'(hist.size()));
    check("t2_over_ovf", BW'({o_go, o_ovf}), BW'({mover, movf}));
    @(posedge clk_in); #1;
    check("t3_ready_done", BW'({o_ready, o_done}), BW'({!mover, 1'b0}));
  endtask

  task automatic do_review(input int idx);
    int k, j;
    logic [BW-1:0] live;
    live = exp_board();
    @(negedge clk_in); rq = 1'b1; ri = 7'(idx);
    @(posedge clk_in); #1;
    rq = 1'b0;
    if (movf) begin
      repeat (idx + 3) @(posedge clk_in);
      #1;
      $display("review sel=%0d idx=%0d ignored (overflow) vv=%0d", sel, idx, o_vv);
      check("rev_ignored_view", o_view, mview);
      check("rev_ignored_vv", BW'(o_vv), BW'(mvv));
    end else begin
      k = (idx > hist.size()) ? hist.size() : idx;
      j = 1;
      while (!o_vv && j < 200) begin @(posedge clk_in); #1; j++; end
      mview = exp_view(k); mvv = 1'b1;
      $display("review sel=%0d idx=%0d clamped=%0d latency=%0d", sel, idx, k, j);
      check("rev_latency", BW'(j), BW'(k + 2));
      check("rev_view", o_view, mview);
      check("rev_live", o_board, live);
    end
    check("rev_ready", BW'(o_ready), BW'(!mover));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dice;
    vectors = 0; miscompares = 0;
    reset = 1'b1; mv = 1'b0; mp = 1'b0; rq = 1'b0; mr = '0; mc = '0; ri = '0;
    sel = 1'b0; n_cur = 9; depth_cur = 64;
    model_clear();
    do_reset();

    // Basic placement, occupancy and range rejects
    do_move(0, 2, 3);
    do_move(0, 4, 4);
    do_move(0, 2, 3);
    do_move(0, 9, 0);
    do_move(0, 0, 9);
    // Five recorded moves, then replay prefixes and a clamped request
    do_move(0, 0, 0);
    do_move(1, 0, 0);
    do_move(0, 8, 8);
    do_review(3);
    do_review(10);
    do_review(0);
    // Stone, pass, rejected, pass ends the game
    do_move(0, 1, 1);
    do_move(1, 0, 0);
    do_move(0, 1, 1);
    do_move(1, 0, 0);
    repeat (3) begin
      @(posedge clk_in); #1;
      check("over_ready", BW'(o_ready), '0);
    end
    do_review(2);
    do_reset();

    // Reset in the middle of a replay
    do_move(0, 3, 3); do_move(0, 3, 4); do_move(0, 4, 3); do_move(0, 4, 4);
    @(negedge clk_in); rq = 1'b1; ri = 7'(4);
    @(posedge clk_in); #1; rq = 1'b0;
    @(posedge clk_in); #1;
    check("midrep_vv", BW'(o_vv), '0);
    @(negedge clk_in); reset = 1'b1;
    @(posedge clk_in); #1;
    model_clear();
    check("midrep_rst_vv", BW'(o_vv), '0);
    check("midrep_rst_view", o_view, '0);
    check("midrep_rst_board", o_board, '0);
    @(negedge clk_in); reset = 1'b0;
    @(posedge clk_in); #1;

    // Randomized play on the 9x9 engine
    for (int it = 0; it < 80; it++) begin
      dice = int'($urandom_range(0, 99));
      if (mover) begin
        do_review(int'($urandom_range(0, 12)));
        do_reset();
      end else if (dice < 12) do_review(int'($urandom_range(0, 12)));
      else if (dice < 22) do_move(1, 0, 0);
      else do_move(0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    // 19x19 engine with a 4-entry history
    sel = 1'b1; n_cur = 19; depth_cur = 4;
    do_reset();
    do_move(0, 18, 18);
    check("corner_cell", BW'(o_board[2*360 +: 2]), BW'(2'b01));
    do_move(0, 0, 0); do_move(0, 0, 1); do_move(0, 0, 2); do_move(0, 0, 3);
    check("ovf_cell", BW'(o_board[2*3 +: 2]), BW'(2'b01));
    do_review(3);
    for (int it = 0; it < 30; it++) begin
      dice = int'($urandom_range(0, 99));
      if (mover) begin
        do_reset();
      end else if (dice < 10) do_review(int'($urandom_range(0, 7)));
      else if (dice < 18) do_move(1, 0, 0);
      else do_move(0, int'($urandom_range(0, 19)), int'($urandom_range(0, 19)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
